// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and sizing for the truth-table sweeper.
// Holds the FSM state encoding and the settle-counter width.
package truth_table_sweeper_pkg;

    localparam int NUM_INPUTS  = 6;
    localparam int NUM_VECTORS = 64;
    localparam int CNT_W       = 4;

    localparam logic [NUM_INPUTS-1:0] LAST_VEC = 6'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } state_t;

    // Settle hold time squeezed into the counter width, never below one cycle.
    function automatic logic [CNT_W-1:0] settle_value(input int unsigned n);
        if (n < 1)
            return CNT_W'(1);
        if (n > (2 ** CNT_W) - 1)
            return CNT_W'((2 ** CNT_W) - 1);
        return CNT_W'(n);
    endfunction

endpackage

// File: rtl/truth_table_sweeper_settle.sv
// Settle down-counter: loads a hold time and flags the last hold cycle.
// expire is high while the count sits at 1.
module sweep_settle_timer
    import truth_table_sweeper_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             tick,
    input  logic [CNT_W-1:0] value,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (tick && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks a 6-input cone through all 64 vectors, captures its truth table
// and compares it against a golden table latched at start.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_VECTORS-1:0] expected,
    output logic [NUM_INPUTS-1:0]  x,
    input  logic                   y_in,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_VECTORS-1:0] tt,
    output logic                   mismatch,
    output logic [NUM_INPUTS-1:0]  first_fail
);

    localparam logic [CNT_W-1:0] SETTLE_VAL = settle_value(SETTLE_CYCLES);

    state_t                 state;
    state_t                 state_n;
    logic [NUM_VECTORS-1:0] exp_q;
    logic                   load;
    logic                   tick;
    logic                   expire;

    sweep_settle_timer u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .tick   (tick),
        .value  (SETTLE_VAL),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        tick    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = APPLY;
                    load    = 1'b1;
                end
            end
            APPLY: begin
                tick = 1'b1;
                if (expire)
                    state_n = SAMPLE;
            end
            SAMPLE: begin
                if (x == LAST_VEC) begin
                    state_n = DONE;
                end else begin
                    state_n = APPLY;
                    load    = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Results are only touched on start and in SAMPLE, so they hold past DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x          <= '0;
            exp_q      <= '0;
            tt         <= '0;
            mismatch   <= 1'b0;
            first_fail <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        exp_q      <= expected;
                        tt         <= '0;
                        mismatch   <= 1'b0;
                        first_fail <= '0;
                        x          <= '0;
                    end
                end
                SAMPLE: begin
                    tt[x] <= y_in;
                    if (y_in != exp_q[x] && !mismatch) begin
                        mismatch   <= 1'b1;
                        first_fail <= x;
                    end
                    if (x != LAST_VEC)
                        x <= x + 6'd1;
                end
                DONE: begin
                    x <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == APPLY) || (state == SAMPLE);
    assign done = (state == DONE);

endmodule
